// File: rtl/pc_pkg.sv
// Shared types for the push-button program-counter stepper: action codes
// and debouncer FSM states.
package pc_pkg;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_CLR  = 3'd1,
    ACT_LOAD = 3'd2,
    ACT_INC  = 3'd3,
    ACT_DEC  = 3'd4
  } act_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    ARMED = 2'd2,
    FIRE  = 2'd3
  } db_state_e;

  localparam int ACT_W = 3;

  // Counter width able to hold 0..max_cnt without wrapping.
  function automatic int db_cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// One push-button channel: 2-flop synchroniser, saturating hold counter and
// a press/release FSM that emits a single-cycle fire pulse on release.
module pb_debounce
  import pc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_n,
  output logic fire
);

  localparam int CNT_W = db_cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             level_n;
  db_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  // Synchronisers idle high so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pb_n};
    end
  end

  assign level_n = sync_q[1];

  // The IDLE->PRESS edge already counts the first low cycle, so a low of
  // exactly DEBOUNCE_CYC synchronised cycles reaches ARMED.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!level_n) begin
          cnt_d   = CNT_ONE;
          state_d = (DEBOUNCE_CYC <= 1) ? ARMED : PRESS;
        end
      end
      PRESS: begin
        if (level_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (level_n) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  assign fire = (state == FIRE);

endmodule

// File: rtl/pc_stepper.sv
// Push-button program-counter stepper: per-button debouncers feeding a
// CLR > LOAD > INC > DEC priority arbiter and the registered PC.
// Optional decrement button is built only when PC_STEPPER_DEC_EN is defined.
module pc_stepper
  import pc_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int STEP         = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pb_clr_n,
  input  logic            pb_load_n,
  input  logic            pb_inc_n,
`ifdef PC_STEPPER_DEC_EN
  input  logic            pb_dec_n,
`endif
  input  logic [PC_W-1:0] pc_in,
  output logic [PC_W-1:0] pc_out,
  output logic            evt,
  output logic [ACT_W-1:0] evt_code
);

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  logic clr_fire, load_fire, inc_fire, dec_fire;
  act_e act_d;

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_clr_n), .fire(clr_fire)
  );

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_load (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_load_n), .fire(load_fire)
  );

  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_inc_n), .fire(inc_fire)
  );

`ifdef PC_STEPPER_DEC_EN
  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_dec_n), .fire(dec_fire)
  );
`else
  assign dec_fire = 1'b0;
`endif

  // Lower-priority pulses that coincide with a higher one are dropped.
  always_comb begin
    act_d = ACT_NONE;
    if (clr_fire) begin
      act_d = ACT_CLR;
    end else if (load_fire) begin
      act_d = ACT_LOAD;
    end else if (inc_fire) begin
      act_d = ACT_INC;
    end else if (dec_fire) begin
`ifdef PC_STEPPER_DEC_EN
      act_d = ACT_DEC;
`else
      act_d = ACT_NONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out   <= '0;
      evt      <= 1'b0;
      evt_code <= ACT_NONE;
    end else begin
      case (act_d)
        ACT_CLR:  pc_out <= '0;
        ACT_LOAD: pc_out <= pc_in;
        ACT_INC:  pc_out <= pc_out + STEP_V;
`ifdef PC_STEPPER_DEC_EN
        ACT_DEC:  pc_out <= pc_out - STEP_V;
`endif
        default:  pc_out <= pc_out;
      endcase
      evt      <= (act_d != ACT_NONE);
      evt_code <= act_d;
    end
  end

endmodule

// File: tb/tb_pc_stepper.sv
// Directed bench for pc_stepper (PC_W=8, DEBOUNCE_CYC=4, STEP=1).
module tb_pc_stepper;
  import pc_pkg::*;

  localparam int PC_W = 8;
  localparam int DEB  = 4;

  logic            clk;
  logic            rst_n;
  logic            pb_clr_n;
  logic            pb_load_n;
  logic            pb_inc_n;
`ifdef PC_STEPPER_DEC_EN
  logic            pb_dec_n;
`endif
  logic [PC_W-1:0] pc_in;
  logic [PC_W-1:0] pc_out;
  logic            evt;
  logic [2:0]      evt_code;

  int errors = 0;
  int checks = 0;

  pc_stepper #(.PC_W(PC_W), .DEBOUNCE_CYC(DEB), .STEP(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pb_clr_n(pb_clr_n),
    .pb_load_n(pb_load_n),
    .pb_inc_n(pb_inc_n),
`ifdef PC_STEPPER_DEC_EN
    .pb_dec_n(pb_dec_n),
`endif
    .pc_in(pc_in),
    .pc_out(pc_out),
    .evt(evt),
    .evt_code(evt_code)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: mask bits {dec, inc, load, clr}; inputs change on falling edges.
  task automatic drive_btns(input logic [3:0] mask, input logic lvl);
    if (mask[0]) pb_clr_n  = lvl;
    if (mask[1]) pb_load_n = lvl;
    if (mask[2]) pb_inc_n  = lvl;
`ifdef PC_STEPPER_DEC_EN
    if (mask[3]) pb_dec_n  = lvl;
`endif
  endtask

  task automatic press(input logic [3:0] mask, input int cycles);
    @(negedge clk);
    drive_btns(mask, 1'b0);
    repeat (cycles) @(negedge clk);
    drive_btns(mask, 1'b1);
  endtask

  // Watches a window after release: event count, when the first event
  // landed, its code, final pc, and that evt_code is NONE while evt is low.
  task automatic observe(input string tag, input int exp_n, input logic [2:0] exp_code,
                         input logic [7:0] exp_pc, input int win);
    int n, at, bad;
    logic [2:0] code;
    n = 0; at = 0; bad = 0; code = 3'd0;
    for (int i = 1; i <= win; i++) begin
      @(negedge clk);
      if (evt) begin
        n++;
        if (at == 0) begin
          at   = i;
          code = evt_code;
        end
      end else if (evt_code !== ACT_NONE) begin
        bad++;
      end
    end
    check({tag, ".evt_count"}, n, exp_n);
    if (exp_n > 0) begin
      check({tag, ".latency"}, at, 4);
      check({tag, ".code"}, {29'd0, code}, {29'd0, exp_code});
    end
    check({tag, ".pc"}, {24'd0, pc_out}, {24'd0, exp_pc});
    check({tag, ".idle_code"}, bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; pb_clr_n = 1'b1; pb_load_n = 1'b1; pb_inc_n = 1'b1;
`ifdef PC_STEPPER_DEC_EN
    pb_dec_n = 1'b1;
`endif
    pc_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset.pc", {24'd0, pc_out}, 32'h0);
    check("reset.evt", {31'd0, evt}, 32'h0);
    check("reset.code", {29'd0, evt_code}, 32'h0);
    rst_n = 1'b1;

    // Bounce: one cycle short of qualification
    press(4'b0100, DEB - 1);
    observe("bounce", 0, ACT_NONE, 8'h00, 8);

    // Minimal valid increment
    press(4'b0100, DEB);
    observe("inc", 1, ACT_INC, 8'h01, 8);

    // Load then clear
    pc_in = 8'hA5;
    press(4'b0010, DEB);
    observe("load", 1, ACT_LOAD, 8'hA5, 8);
    press(4'b0001, DEB);
    observe("clr", 1, ACT_CLR, 8'h00, 8);
    press(4'b0001, DEB);
    observe("clr_at_zero", 1, ACT_CLR, 8'h00, 8);

    // Wrap at max
    pc_in = 8'hFF;
    press(4'b0010, DEB);
    observe("load_ff", 1, ACT_LOAD, 8'hFF, 8);
    press(4'b0100, DEB);
    observe("inc_wrap", 1, ACT_INC, 8'h00, 8);

`ifdef PC_STEPPER_DEC_EN
    press(4'b1000, DEB);
    observe("dec_wrap", 1, ACT_DEC, 8'hFF, 8);
    press(4'b0001, DEB);
    observe("clr_after_dec", 1, ACT_CLR, 8'h00, 8);
`endif

    // Long hold gives exactly one action
    press(4'b0100, 100);
    observe("long_hold", 1, ACT_INC, 8'h01, 8);

    // Priority: clr and inc released together
    pc_in = 8'h05;
    press(4'b0010, DEB);
    observe("load_5", 1, ACT_LOAD, 8'h05, 8);
    press(4'b0101, DEB);
    observe("prio", 1, ACT_CLR, 8'h00, 12);

    // Consecutive-cycle actions from different buttons are both applied
    pc_in = 8'h10;
    @(negedge clk);
    pb_load_n = 1'b0; pb_inc_n = 1'b0;
    repeat (DEB) @(negedge clk);
    pb_load_n = 1'b1;
    @(negedge clk);
    pb_inc_n = 1'b1;
    repeat (3) @(negedge clk);
    check("back2back.evt1", {31'd0, evt}, 32'h1);
    check("back2back.code1", {29'd0, evt_code}, {29'd0, ACT_LOAD});
    check("back2back.pc1", {24'd0, pc_out}, 32'h10);
    @(negedge clk);
    check("back2back.evt2", {31'd0, evt}, 32'h1);
    check("back2back.code2", {29'd0, evt_code}, {29'd0, ACT_INC});
    check("back2back.pc2", {24'd0, pc_out}, 32'h11);
    observe("back2back.tail", 0, ACT_NONE, 8'h11, 8);

    // Reset mid-press discards the press
    @(negedge clk);
    pb_inc_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.pc", {24'd0, pc_out}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pb_inc_n = 1'b1;
    observe("midrst.release", 0, ACT_NONE, 8'h00, 10);
    press(4'b0100, DEB);
    observe("midrst.fresh", 1, ACT_INC, 8'h01, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
